// File: rtl/arb_pkg.sv
// Shared types for the round-robin burst arbiter.
package arb_pkg;
    typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/bin2onehot.sv
// Binary index to one-hot decoder.
module bin2onehot #(
    parameter  int unsigned ONEHOT_WIDTH = 4,
    localparam int unsigned BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic [ONEHOT_WIDTH-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
            if (bin == BIN_WIDTH'(i)) onehot[i] = 1'b1;
        end
    end
endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NUM_REQ requesters,
// holding each grant until the winner's last beat is accepted.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_WIDTH  = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [DATA_WIDTH-1:0] req_data_i [NUM_REQ],
    input  logic [NUM_REQ-1:0]    req_last_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [IDX_WIDTH-1:0]  gnt_idx_o,
    output logic [NUM_REQ-1:0]    gnt_onehot_o
);
    arb_state_e           state;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] lock_idx;
    logic [IDX_WIDTH-1:0] sel;
    logic                 any_valid;
    logic                 gnt_active;
    logic                 accept;
    logic [NUM_REQ-1:0]   onehot_raw;

    // Explicit wrap so non-power-of-two NUM_REQ never yields an out-of-range index.
    function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
        if (32'(idx) >= NUM_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] rr_search(input logic [NUM_REQ-1:0]   valid,
                                                      input logic [IDX_WIDTH-1:0] ptr);
        logic [IDX_WIDTH-1:0] pick;
        logic                 found;
        int unsigned          cand;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && valid[IDX_WIDTH'(cand)]) begin
                pick  = IDX_WIDTH'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_valid = |req_valid_i;
    assign sel       = rr_search(req_valid_i, rr_ptr);

    // Reset gates the grant so the channel is silent while rst_ni is low.
    always_comb begin
        gnt_idx_o   = rr_ptr;
        gnt_active  = 1'b0;
        out_valid_o = 1'b0;
        if (state == ARB_LOCKED) begin
            gnt_idx_o   = lock_idx;
            gnt_active  = rst_ni;
            out_valid_o = rst_ni & req_valid_i[lock_idx];
        end else if (any_valid) begin
            gnt_idx_o   = sel;
            gnt_active  = rst_ni;
            out_valid_o = rst_ni;
        end
    end

    assign out_data_o = req_data_i[gnt_idx_o];
    assign out_last_o = req_last_i[gnt_idx_o];

    bin2onehot #(.ONEHOT_WIDTH(NUM_REQ)) u_onehot (
        .bin    (gnt_idx_o),
        .onehot (onehot_raw)
    );

    assign gnt_onehot_o = gnt_active ? onehot_raw : '0;
    assign req_ready_o  = gnt_onehot_o & {NUM_REQ{out_ready_i}};
    assign accept       = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_valid) begin
                        if (accept && out_last_o) begin
                            rr_ptr <= next_idx(sel);
                        end else begin
                            state    <= ARB_LOCKED;
                            lock_idx <= sel;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (accept && out_last_o) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= next_idx(lock_idx);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic                  stall_q;
    logic [IDX_WIDTH-1:0]  stall_idx_q;
    logic [DATA_WIDTH-1:0] stall_data_q;
    logic                  stall_last_q;

    // A stalled granted beat must be presented unchanged on the following edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q      <= 1'b0;
            stall_idx_q  <= '0;
            stall_data_q <= '0;
            stall_last_q <= 1'b0;
        end else begin
            if (stall_q) begin
                assert (req_valid_i[stall_idx_q] && req_data_i[stall_idx_q] == stall_data_q
                        && req_last_i[stall_idx_q] == stall_last_q);
            end
            assert ($onehot0(gnt_onehot_o));
            stall_q      <= out_valid_o & ~out_ready_i;
            stall_idx_q  <= gnt_idx_o;
            stall_data_q <= out_data_o;
            stall_last_q <= out_last_o;
        end
    end
`endif
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-free behavioural arbitration model.
module tb_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic [1:0]    gnt_idx;
    logic [N-1:0]  gnt_onehot;

    rr_burst_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .out_ready_i  (out_ready),
        .gnt_idx_o    (gnt_idx),
        .gnt_onehot_o (gnt_onehot)
    );

    // Three-requester instance for the non-power-of-two wrap case.
    logic [2:0]    v3 = '0;
    logic [2:0]    l3 = '1;
    logic [DW-1:0] d3 [3];
    logic [2:0]    rdy3;
    logic          ov3, ol3;
    logic [DW-1:0] od3;
    logic [1:0]    gi3;
    logic [2:0]    go3;
    logic          ordy3 = 1'b1;

    rr_burst_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) dut3 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (v3),
        .req_data_i   (d3),
        .req_last_i   (l3),
        .req_ready_o  (rdy3),
        .out_valid_o  (ov3),
        .out_data_o   (od3),
        .out_last_o   (ol3),
        .out_ready_i  (ordy3),
        .gnt_idx_o    (gi3),
        .gnt_onehot_o (go3)
    );

    int total = 0;
    int bad   = 0;

    // Staged stimulus, applied at each falling edge by step().
    bit            s_rst = 1'b0;
    bit [N-1:0]    s_valid;
    bit [N-1:0]    s_last;
    logic [DW-1:0] s_data [N];
    bit            s_ready;
    int            left [N];

    // Model state: whether a burst owns the channel, who, and the rotation pointer.
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    bit acc_o;
    int g_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int         g;
        bit         act, ov, acc;
        logic [N-1:0] eoh;
        acc_o = 1'b0;
        g_o   = 0;
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_onehot", 64'(gnt_onehot), 64'(0));
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            return;
        end
        if (m_locked) begin
            g   = m_owner;
            act = 1'b1;
            ov  = s_valid[g];
        end else if (s_valid != 0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && s_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            act = 1'b1;
            ov  = 1'b1;
        end else begin
            g   = m_ptr;
            act = 1'b0;
            ov  = 1'b0;
        end
        eoh = '0;
        if (act) eoh[g] = 1'b1;
        chk("gnt_idx", 64'(gnt_idx), 64'(g));
        chk("gnt_onehot", 64'(gnt_onehot), 64'(eoh));
        chk("req_ready", 64'(req_ready), s_ready ? 64'(eoh) : 64'(0));
        chk("out_valid", 64'(out_valid), 64'(ov));
        chk("out_data", 64'(out_data), 64'(s_data[g]));
        chk("out_last", 64'(out_last), 64'(s_last[g]));
        acc = ov && s_ready;
        if (acc && s_last[g]) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % N;
        end else if (!m_locked && act) begin
            m_locked = 1'b1;
            m_owner  = g;
        end
        acc_o = acc;
        g_o   = g;
    endtask

    task automatic step();
        @(negedge clk);
        rst_n     = s_rst;
        req_valid = s_valid;
        req_last  = s_last;
        for (int r = 0; r < N; r++) req_data[r] = s_data[r];
        out_ready = s_ready;
        #1;
        model_check();
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            req_data[r] = '0;
            s_data[r]   = 32'hA000_0000 + DW'(r);
            left[r]     = 0;
        end
        for (int r = 0; r < 3; r++) d3[r] = 32'h3000_0000 + DW'(r);

        // Reset held with requests pending: channel must stay silent.
        s_valid = '1; s_last = '1; s_ready = 1'b1;
        step();
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_onehot", 64'(gnt_onehot), 64'(0));
        chk("reset_ready", 64'(req_ready), 64'(0));
        step();

        s_rst = 1'b1; s_valid = '0;
        step();
        chk("idle_out_valid", 64'(out_valid), 64'(0));
        chk("idle_onehot", 64'(gnt_onehot), 64'(0));
        chk("idle_ready", 64'(req_ready), 64'(0));
        chk("idle_gnt_idx", 64'(gnt_idx), 64'(0));

        // Rotation with single-beat bursts.
        s_valid = '1; s_last = '1; s_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rotation_gnt", 64'(gnt_idx), 64'(i % 4));
        end

        // 3-beat burst from 1 while 0 waits.
        s_valid = 4'b0011; s_last = 4'b0001;
        step(); chk("burst_b1_gnt", 64'(gnt_idx), 64'(1));
        s_data[1] = 32'hB1;
        step(); chk("burst_b2_gnt", 64'(gnt_idx), 64'(1));
        s_data[1] = 32'hB2; s_last = 4'b0011;
        step(); chk("burst_b3_gnt", 64'(gnt_idx), 64'(1));
        s_valid = 4'b0001;
        step(); chk("burst_after_gnt", 64'(gnt_idx), 64'(0));
        s_valid = '0;
        step(); chk("burst_idle_ptr", 64'(gnt_idx), 64'(1));

        // Stall on requester 2's first beat, then a 2-cycle bubble with 3 waiting.
        s_valid = 4'b1100; s_last = 4'b1000; s_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_gnt", 64'(gnt_idx), 64'(2));
            chk("stall_ready3", 64'(req_ready[3]), 64'(0));
        end
        s_ready = 1'b1;
        step(); chk("stall_accept_gnt", 64'(gnt_idx), 64'(2));
        s_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bubble_gnt", 64'(gnt_idx), 64'(2));
            chk("bubble_valid", 64'(out_valid), 64'(0));
            chk("bubble_ready3", 64'(req_ready[3]), 64'(0));
        end
        s_valid = 4'b1100; s_last = 4'b1100; s_data[2] = 32'hC2;
        step(); chk("stall_last_gnt", 64'(gnt_idx), 64'(2));
        s_valid = 4'b1000;
        step(); chk("after_stall_gnt", 64'(gnt_idx), 64'(3));

        // Reset during beat 2 of a 4-beat burst from 3.
        s_valid = 4'b1000; s_last = '0;
        step(); chk("rstmid_b1_gnt", 64'(gnt_idx), 64'(3));
        s_data[3] = 32'hD3;
        step(); chk("rstmid_b2_gnt", 64'(gnt_idx), 64'(3));
        rst_n = 1'b0; s_rst = 1'b0;
        #1;
        chk("rstmid_out_valid", 64'(out_valid), 64'(0));
        chk("rstmid_onehot", 64'(gnt_onehot), 64'(0));
        chk("rstmid_ready", 64'(req_ready), 64'(0));
        m_locked = 1'b0; m_ptr = 0; m_owner = 0;
        step(); step();
        s_rst = 1'b1; s_valid = 4'b1010; s_last = '1;
        step(); chk("rstmid_restart_gnt", 64'(gnt_idx), 64'(1));

        // Random traffic: a presented beat is held until accepted.
        s_valid = '0;
        for (int r = 0; r < N; r++) left[r] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < N; r++) begin
                if (!s_valid[r] && $urandom_range(0, 3) != 0) begin
                    if (left[r] == 0) left[r] = $urandom_range(1, 4);
                    s_valid[r] = 1'b1;
                    s_last[r]  = (left[r] == 1);
                    s_data[r]  = $urandom;
                end
            end
            s_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc_o) begin
                s_valid[g_o] = 1'b0;
                left[g_o]--;
            end
        end

        // NUM_REQ=3: pointer wraps from 2 to 0.
        @(negedge clk); v3 = 3'b100; #1;
        chk("w3_gnt2", 64'(gi3), 64'(2));
        @(negedge clk); v3 = 3'b000; #1;
        chk("w3_idle_ptr", 64'(gi3), 64'(0));
        chk("w3_idle_onehot", 64'(go3), 64'(0));
        @(negedge clk); v3 = 3'b101; #1;
        chk("w3_gnt0", 64'(gi3), 64'(0));
        @(negedge clk); #1;
        chk("w3_then2", 64'(gi3), 64'(2));
        @(negedge clk); #1;
        chk("w3_then0", 64'(gi3), 64'(0));
        chk("w3_ready", 64'(rdy3), 64'(3'b001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
